// File: rtl/alu_result_serializer_if.sv
// Result handshake between the ALU core and the byte-serial result transmitter.
// The ALU side is the master; the serializer is the slave.
interface alu_result_serializer_if;
   logic [31:0] res_data;
   logic [4:0]  res_flags;
   logic        res_valid;
   logic        res_ready;

   modport master (
      output res_data,
      output res_flags,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_flags,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/alu_result_serializer.sv
// Sends one captured ALU result to the host as a status byte followed by the data bytes, MSB first.
// Each byte uses a four-phase strobe/ack handshake, with the ack brought in through a synchronizer.
module alu_result_serializer #(
   parameter int DATA_BYTES  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   alu_result_serializer_if.slave        res,
   output logic [7:0]                    uo_out,
   output logic                          out_strobe,
   input  logic                          host_ack,
   output logic                          busy
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      PRESENT,
      RELEASE
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(DATA_BYTES);

   state_t                  state;
   state_t                  state_nxt;
   logic [2:0]              idx;
   logic [2:0]              idx_nxt;
   logic [2:0]              idx_inc;
   logic [8*DATA_BYTES-1:0] cap_data;
   logic [8*DATA_BYTES-1:0] shifted;
   logic [7:0]              data_byte;
   logic [7:0]              uo_nxt;
   logic                    strobe_nxt;
   logic                    capture;
   logic                    ready_q;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    ack_s;

   assign res.res_ready = ready_q;

   // host_ack is asynchronous; the FSM only ever looks at the last synchronizer flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else if (ena) begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], host_ack};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   assign idx_inc   = idx + 3'd1;
   assign shifted   = cap_data >> (8 * (DATA_BYTES - int'(idx_inc)));
   assign data_byte = shifted[7:0];

   // uo_out is loaded on the edge that enters SETUP, so data leads the strobe by one cycle.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      uo_nxt     = uo_out;
      strobe_nxt = out_strobe;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            uo_nxt     = 8'h00;
            strobe_nxt = 1'b0;
            if (res.res_valid && ready_q) begin
               capture   = 1'b1;
               idx_nxt   = 3'd0;
               uo_nxt    = {3'b101, res.res_flags};
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            strobe_nxt = 1'b1;
            state_nxt  = PRESENT;
         end
         PRESENT: begin
            if (ack_s) begin
               strobe_nxt = 1'b0;
               state_nxt  = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack_s) begin
               if (idx == LAST_IDX) begin
                  uo_nxt    = 8'h00;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = idx_inc;
                  uo_nxt    = data_byte;
                  state_nxt = SETUP;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // With ena low every register holds, so a transfer resumes exactly where it paused.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         uo_out     <= 8'h00;
         out_strobe <= 1'b0;
         ready_q    <= 1'b1;
         busy       <= 1'b0;
         cap_data   <= '0;
      end else if (ena) begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         uo_out     <= uo_nxt;
         out_strobe <= strobe_nxt;
         ready_q    <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
         if (capture) begin
            cap_data <= res.res_data;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: vector table of results with expected byte streams,
// a host model that pops the scoreboard on every strobe, and hand-written corner sequences.
module tb_alu_result_serializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       host_ack;
   logic [7:0] uo_out;
   logic       out_strobe;
   logic       busy;

   alu_result_serializer_if rif ();

   alu_result_serializer #(
      .DATA_BYTES  (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .res        (rif),
      .uo_out     (uo_out),
      .out_strobe (out_strobe),
      .host_ack   (host_ack),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  flags;
      logic [39:0] bytes;
   } vec_t;

   vec_t       vecs [6];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];
   int         rise_cyc [$];
   int         ack_delay = 0;
   bit         stuck_last = 1'b0;
   logic [7:0] last_byte = 8'h00;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: event did not occur as required", name);
   endtask

   // Host model: acks each strobe after ack_delay cycles and checks the byte against the scoreboard.
   initial begin
      logic [7:0] exp;
      host_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            host_ack = 1'b0;
         end else if (out_strobe && !host_ack) begin
            rise_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               failNow("unexpected_byte");
               exp = uo_out;
            end else begin
               exp = sb.pop_front();
               checkOutput("byte", {32'h0, uo_out}, {32'h0, exp});
            end
            last_byte = exp;
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               checkOutput("hold_strobe", {31'h0, out_strobe, uo_out}, {31'h0, 1'b1, exp});
            end
            host_ack = 1'b1;
         end else if (!out_strobe && host_ack && !(stuck_last && sb.size() == 0)) begin
            for (int i = 0; i < ack_delay; i++) begin
               @(negedge clk);
               checkOutput("hold_release", {31'h0, out_strobe, uo_out}, {31'h0, 1'b0, last_byte});
            end
            host_ack = 1'b0;
         end
      end
   end

   // Offers one result, pushes its expected bytes at the capture edge and returns on the next negedge.
   task automatic applyStimulus(input vec_t v, input bit hold, output int e0);
      bit captured;
      captured = 1'b0;
      e0 = 0;
      @(negedge clk);
      rif.res_data  = v.data;
      rif.res_flags = v.flags;
      rif.res_valid = 1'b1;
      for (int i = 0; i < 400 && !captured; i++) begin
         if (rif.res_ready && ena) begin
            for (int k = 0; k < 5; k++) sb.push_back(v.bytes[39-8*k -: 8]);
            @(posedge clk);
            #1 e0 = cyc;
            captured = 1'b1;
         end
         @(negedge clk);
      end
      if (!captured) failNow("capture_timeout");
      if (!hold) rif.res_valid = 1'b0;
   endtask

   task automatic waitIdle(input int e0, input int bound, output int elapsed);
      bit found;
      found = 1'b0;
      elapsed = -1;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge clk);
         if (rif.res_ready) begin
            found = 1'b1;
            elapsed = cyc - e0;
         end
      end
      if (!found) failNow("idle_timeout");
   endtask

   initial begin
      int  e0;
      int  e0b;
      int  el;
      bit  found;

      vecs[0] = '{32'h3FC00000, 5'h01, 40'hA1_3F_C0_00_00};
      vecs[1] = '{32'h7F800000, 5'h04, 40'hA4_7F_80_00_00};
      vecs[2] = '{32'hC0490FDB, 5'h11, 40'hB1_C0_49_0F_DB};
      vecs[3] = '{32'h12345678, 5'h0A, 40'hAA_12_34_56_78};
      vecs[4] = '{32'h00000000, 5'h00, 40'hA0_00_00_00_00};
      vecs[5] = '{32'hFFFFFFFF, 5'h1F, 40'hBF_FF_FF_FF_FF};

      rst_n         = 1'b0;
      ena           = 1'b1;
      rif.res_valid = 1'b0;
      rif.res_data  = '0;
      rif.res_flags = '0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rif.res_data  = $urandom;
         rif.res_flags = 5'($urandom);
         rif.res_valid = 1'($urandom);
         ena           = 1'($urandom);
      end
      #1;
      checkOutput("rst_uo_out", {32'h0, uo_out}, 40'h00);
      checkOutput("rst_strobe", {39'h0, out_strobe}, 40'h0);
      checkOutput("rst_ready", {39'h0, rif.res_ready}, 40'h1);
      checkOutput("rst_busy", {39'h0, busy}, 40'h0);
      @(negedge clk);
      rif.res_valid = 1'b0;
      ena           = 1'b1;
      rst_n         = 1'b1;

      // Single transfer with an immediate-ack host: latency and per-byte timing.
      rise_cyc.delete();
      applyStimulus(vecs[0], 1'b0, e0);
      checkOutput("setup_uo_out", {32'h0, uo_out}, 40'hA1);
      checkOutput("setup_strobe", {39'h0, out_strobe}, 40'h0);
      checkOutput("setup_busy", {38'h0, busy, rif.res_ready}, 40'h2);
      waitIdle(e0, 200, el);
      checkOutput("single_cycles", 40'(el), 40'd35);
      checkOutput("single_nbytes", 40'(rise_cyc.size()), 40'd5);
      if (rise_cyc.size() == 5) begin
         checkOutput("strobe_latency", 40'(rise_cyc[0] - e0), 40'd1);
         for (int k = 1; k < 5; k++) checkOutput("byte_period", 40'(rise_cyc[k] - rise_cyc[k-1]), 40'd7);
      end
      checkOutput("single_sb_empty", 40'(sb.size()), 40'd0);

      // Back-to-back with the source holding valid: second capture one edge after IDLE.
      applyStimulus(vecs[1], 1'b1, e0);
      applyStimulus(vecs[2], 1'b0, e0b);
      checkOutput("b2b_gap", 40'(e0b - e0), 40'd36);
      waitIdle(e0b, 200, el);
      checkOutput("b2b_cycles", 40'(el), 40'd35);
      checkOutput("b2b_sb_empty", 40'(sb.size()), 40'd0);

      for (int t = 3; t < 6; t++) begin
         applyStimulus(vecs[t], 1'b0, e0);
         waitIdle(e0, 200, el);
         checkOutput("table_cycles", 40'(el), 40'd35);
         checkOutput("table_sb_empty", 40'(sb.size()), 40'd0);
      end

      // Slow host: 20 extra cycles per ack phase stretch each byte from 7 to 47 cycles.
      ack_delay = 20;
      applyStimulus(vecs[3], 1'b0, e0);
      waitIdle(e0, 1000, el);
      checkOutput("slow_cycles", 40'(el), 40'd235);
      checkOutput("slow_sb_empty", 40'(sb.size()), 40'd0);
      ack_delay = 0;

      // Ack stuck high after the last byte: block must stay in RELEASE.
      stuck_last = 1'b1;
      rise_cyc.delete();
      applyStimulus(vecs[0], 1'b0, e0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         #1;
         if (rise_cyc.size() == 5) found = 1'b1;
      end
      if (!found) failNow("stuck_last_byte");
      repeat (30) @(negedge clk);
      checkOutput("stuck_state", {37'h0, rif.res_ready, busy, out_strobe}, 40'b010);
      stuck_last = 1'b0;
      waitIdle(e0, 200, el);
      checkOutput("stuck_sb_empty", 40'(sb.size()), 40'd0);

      // ena dropped for 10 cycles while byte index 2 is presented.
      rise_cyc.delete();
      applyStimulus(vecs[2], 1'b0, e0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         #1;
         if (rise_cyc.size() == 3) found = 1'b1;
      end
      if (!found) failNow("ena_byte2");
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("ena_freeze", {30'h0, busy, out_strobe, uo_out}, {30'h0, 1'b1, 1'b1, vecs[2].bytes[23:16]});
      end
      ena = 1'b1;
      waitIdle(e0, 200, el);
      checkOutput("ena_nbytes", 40'(rise_cyc.size()), 40'd5);
      checkOutput("ena_sb_empty", 40'(sb.size()), 40'd0);

      // Reset during RELEASE of byte index 3, then a fresh transfer.
      rise_cyc.delete();
      applyStimulus(vecs[5], 1'b0, e0);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         #1;
         if (rise_cyc.size() == 4 && !out_strobe && busy) found = 1'b1;
      end
      if (!found) failNow("rst_release_byte3");
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_outputs", {29'h0, rif.res_ready, busy, out_strobe, uo_out}, {29'h0, 1'b1, 1'b0, 1'b0, 8'h00});
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rise_cyc.delete();
      applyStimulus(vecs[4], 1'b0, e0);
      checkOutput("postrst_status", {32'h0, uo_out}, 40'hA0);
      waitIdle(e0, 200, el);
      checkOutput("postrst_cycles", 40'(el), 40'd35);
      checkOutput("postrst_sb_empty", 40'(sb.size()), 40'd0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
